// File: rtl/xlate_arbiter_pkg.sv
// xlate_arbiter_pkg: shared segment constants, widths and defaults for the translation arbiter
package xlate_arbiter_pkg;
  localparam int VPN_W = 20;
  localparam int STARVE_MAX_DEF = 4;
  localparam logic [3:0] SEG_KSEG0_LO = 4'h8;
  localparam logic [3:0] SEG_KSEG0_HI = 4'h9;
  localparam logic [3:0] SEG_KSEG1_LO = 4'hA;
  localparam logic [3:0] SEG_KSEG1_HI = 4'hB;
  function automatic logic [3:0] seg_of(input logic [VPN_W-1:0] vpn);
    return vpn[VPN_W-1 -: 4];
  endfunction
endpackage

// File: rtl/xlate_arbiter_map.sv
// xlate_map: combinational MIPS fixed-segment vpn -> {pfn, uncache}; vpn_i in, pfn_o/uncache_o out; KSEG0_CACHE_EN makes kseg0 cacheable
module xlate_map
  import xlate_arbiter_pkg::*;
(
  input  logic [VPN_W-1:0] vpn_i,
  output logic [VPN_W-1:0] pfn_o,
  output logic             uncache_o
);
  logic is_k0, is_k1;
  assign is_k0 = seg_of(vpn_i) inside {SEG_KSEG0_LO, SEG_KSEG0_HI};
  assign is_k1 = seg_of(vpn_i) inside {SEG_KSEG1_LO, SEG_KSEG1_HI};
  assign pfn_o = is_k1 ? {3'b000, vpn_i[16:0]} : is_k0 ? {1'b0, vpn_i[18:0]} : vpn_i;
`ifdef KSEG0_CACHE_EN
  assign uncache_o = ~is_k0;
`else
  assign uncache_o = 1'b1;
`endif
endmodule

// File: rtl/xlate_arbiter.sv
// xlate_arbiter: shares one xlate_map between IF and DM with DM priority, anti-starvation counter and per-port response slots; ports clk/reset, {if,dm}_req/vpn/gnt, {if,dm}_rsp_valid/ready/pfn/uncache; honours KSEG0_CACHE_EN via xlate_map
module xlate_arbiter
  import xlate_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req,
  input  logic [VPN_W-1:0] if_vpn,
  output logic             if_gnt,
  output logic             if_rsp_valid,
  input  logic             if_rsp_ready,
  output logic [VPN_W-1:0] if_rsp_pfn,
  output logic             if_rsp_uncache,
  input  logic             dm_req,
  input  logic [VPN_W-1:0] dm_vpn,
  output logic             dm_gnt,
  output logic             dm_rsp_valid,
  input  logic             dm_rsp_ready,
  output logic [VPN_W-1:0] dm_rsp_pfn,
  output logic             dm_rsp_uncache
);
  logic             if_elig, dm_elig, if_pri;
  logic             if_valid_q, dm_valid_q, if_unc_q, dm_unc_q, map_unc;
  logic [VPN_W-1:0] if_pfn_q, dm_pfn_q, map_pfn;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  // a slot draining this cycle can be refilled in the same cycle
  assign if_elig = if_req & (~if_valid_q | if_rsp_ready);
  assign dm_elig = dm_req & (~dm_valid_q | dm_rsp_ready);
  assign if_pri  = starve_cnt_q == CNT_W'(STARVE_MAX);
  assign if_gnt  = ~reset & if_elig & (if_pri | ~dm_elig);
  assign dm_gnt  = ~reset & dm_elig & ~(if_pri & if_elig);
  xlate_map u_map (
    .vpn_i    (if_gnt ? if_vpn : dm_vpn),
    .pfn_o    (map_pfn),
    .uncache_o(map_unc)
  );
  always_comb begin
    starve_cnt_d = (if_gnt | ~if_req) ? '0 :
                   (dm_gnt & ~if_pri) ? starve_cnt_q + CNT_W'(1) : starve_cnt_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_valid_q   <= 1'b0;
      dm_valid_q   <= 1'b0;
      if_pfn_q     <= '0;
      dm_pfn_q     <= '0;
      if_unc_q     <= 1'b0;
      dm_unc_q     <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      if (if_gnt) begin
        if_valid_q <= 1'b1;
        if_pfn_q   <= map_pfn;
        if_unc_q   <= map_unc;
      end else if (if_rsp_ready) begin
        if_valid_q <= 1'b0;
      end
      if (dm_gnt) begin
        dm_valid_q <= 1'b1;
        dm_pfn_q   <= map_pfn;
        dm_unc_q   <= map_unc;
      end else if (dm_rsp_ready) begin
        dm_valid_q <= 1'b0;
      end
      starve_cnt_q <= starve_cnt_d;
    end
  end
  assign if_rsp_valid   = if_valid_q;
  assign if_rsp_pfn     = if_pfn_q;
  assign if_rsp_uncache = if_unc_q;
  assign dm_rsp_valid   = dm_valid_q;
  assign dm_rsp_pfn     = dm_pfn_q;
  assign dm_rsp_uncache = dm_unc_q;
endmodule

// File: tb/tb_xlate_arbiter.sv
// tb_xlate_arbiter: directed test-plan steps plus randomized traffic checked against a behavioural model
module tb_xlate_arbiter;
  localparam int STARVE = 4;
`ifdef KSEG0_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic if_req = 1'b0, if_rsp_ready = 1'b0, dm_req = 1'b0, dm_rsp_ready = 1'b0;
  logic [19:0] if_vpn = '0, dm_vpn = '0, if_rsp_pfn, dm_rsp_pfn;
  logic if_gnt, dm_gnt, if_rsp_valid, dm_rsp_valid, if_rsp_uncache, dm_rsp_uncache;
  int checks = 0, failures = 0;
  logic m_if_v = 1'b0, m_dm_v = 1'b0, m_if_u = 1'b0, m_dm_u = 1'b0;
  logic [19:0] m_if_p = '0, m_dm_p = '0;
  int m_cnt = 0;
  logic obs_ig, obs_dg;
  logic [5:0] ig_hist, dg_hist;
  logic [19:0] held_pfn;
  always #5 clk = ~clk;
  xlate_arbiter #(.STARVE_MAX(STARVE), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_vpn(if_vpn), .if_gnt(if_gnt), .if_rsp_valid(if_rsp_valid),
    .if_rsp_ready(if_rsp_ready), .if_rsp_pfn(if_rsp_pfn), .if_rsp_uncache(if_rsp_uncache),
    .dm_req(dm_req), .dm_vpn(dm_vpn), .dm_gnt(dm_gnt), .dm_rsp_valid(dm_rsp_valid),
    .dm_rsp_ready(dm_rsp_ready), .dm_rsp_pfn(dm_rsp_pfn), .dm_rsp_uncache(dm_rsp_uncache)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // segment table: kseg1 keeps 17 low bits, kseg0 keeps 19, everything else is identity
  function automatic logic [20:0] ref_xlate(input logic [19:0] v);
    int seg;
    seg = int'(v) / 65536;
    if (seg == 10 || seg == 11) return {v % 20'h20000, 1'b1};
    if (seg == 8 || seg == 9) return {v % 20'h80000, ~CACHE_EN};
    return {v, 1'b1};
  endfunction
  function automatic logic [19:0] rand_vpn();
    return {4'($urandom_range(0, 15)), 16'($urandom)};
  endfunction
  task automatic model_reset();
    m_if_v = 1'b0; m_dm_v = 1'b0; m_cnt = 0;
  endtask
  task automatic step();
    logic ie, de, ipri, ig, dg;
    logic [20:0] t;
    @(negedge clk);
    chk("if_rsp_valid", 32'(if_rsp_valid), 32'(m_if_v));
    chk("dm_rsp_valid", 32'(dm_rsp_valid), 32'(m_dm_v));
    if (m_if_v) begin
      chk("if_rsp_pfn", 32'(if_rsp_pfn), 32'(m_if_p));
      chk("if_rsp_uncache", 32'(if_rsp_uncache), 32'(m_if_u));
    end
    if (m_dm_v) begin
      chk("dm_rsp_pfn", 32'(dm_rsp_pfn), 32'(m_dm_p));
      chk("dm_rsp_uncache", 32'(dm_rsp_uncache), 32'(m_dm_u));
    end
    chk("starve_cnt", 32'(dut.starve_cnt_q), 32'(m_cnt));
    ie = if_req && (!m_if_v || if_rsp_ready);
    de = dm_req && (!m_dm_v || dm_rsp_ready);
    ipri = (m_cnt == STARVE);
    ig = ie && (ipri || !de);
    dg = de && !(ipri && ie);
    obs_ig = if_gnt;
    obs_dg = dm_gnt;
    chk("if_gnt", 32'(if_gnt), 32'(ig));
    chk("dm_gnt", 32'(dm_gnt), 32'(dg));
    @(posedge clk);
    if (ig) begin
      t = ref_xlate(if_vpn); m_if_v = 1'b1; m_if_p = t[20:1]; m_if_u = t[0];
    end else if (if_rsp_ready) m_if_v = 1'b0;
    if (dg) begin
      t = ref_xlate(dm_vpn); m_dm_v = 1'b1; m_dm_p = t[20:1]; m_dm_u = t[0];
    end else if (dm_rsp_ready) m_dm_v = 1'b0;
    if (ig || !if_req) m_cnt = 0;
    else if (dg) m_cnt = (m_cnt < STARVE) ? m_cnt + 1 : STARVE;
    #1;
  endtask
  initial begin
    if_req = 1'b1; dm_req = 1'b1;
    #2;
    chk("rst_if_gnt", 32'(if_gnt), 0);
    chk("rst_dm_gnt", 32'(dm_gnt), 0);
    chk("rst_if_valid", 32'(if_rsp_valid), 0);
    chk("rst_dm_valid", 32'(dm_rsp_valid), 0);
    chk("rst_if_pfn", 32'(if_rsp_pfn), 0);
    chk("rst_dm_unc", 32'(dm_rsp_uncache), 0);
    if_req = 1'b0; dm_req = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    // single IF request in kseg1
    if_req = 1'b1; if_vpn = 20'hBFC00; if_rsp_ready = 1'b1; dm_rsp_ready = 1'b1;
    step();
    chk("tp1_gnt", 32'(obs_ig), 1);
    if_req = 1'b0;
    chk("tp1_pfn", 32'(if_rsp_pfn), 32'h1FC00);
    chk("tp1_unc", 32'(if_rsp_uncache), 1);
    step();
    step();
    chk("tp1_drop", 32'(if_rsp_valid), 0);
    // simultaneous requests: DM first
    if_req = 1'b1; if_vpn = 20'h80001; dm_req = 1'b1; dm_vpn = 20'hA0002;
    step();
    chk("tp2_dm_first", {obs_ig, obs_dg}, 2'b01);
    dm_req = 1'b0;
    chk("tp2_dm_pfn", 32'(dm_rsp_pfn), 32'h00002);
    step();
    chk("tp2_if_second", 32'(obs_ig), 1);
    if_req = 1'b0;
    chk("tp2_if_pfn", 32'(if_rsp_pfn), 32'h00001);
    step();
    // starvation: both held continuously
    if_req = 1'b1; dm_req = 1'b1; if_vpn = 20'h12345; dm_vpn = 20'h23456;
    for (int i = 0; i < 6; i++) begin
      step();
      ig_hist[i] = obs_ig; dg_hist[i] = obs_dg;
    end
    chk("tp3_if_pattern", 32'(ig_hist), 32'b010000);
    chk("tp3_dm_pattern", 32'(dg_hist), 32'b101111);
    if_req = 1'b0; dm_req = 1'b0;
    step(); step();
    // backpressure on DM
    dm_req = 1'b1; dm_vpn = 20'hB0077; dm_rsp_ready = 1'b0;
    step();
    held_pfn = dm_rsp_pfn;
    chk("tp4_first_pfn", 32'(held_pfn), 32'h10077);
    dm_vpn = 20'h00400;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("tp4_no_gnt", 32'(obs_dg), 0);
      chk("tp4_stable", 32'(dm_rsp_pfn), 32'(held_pfn));
    end
    dm_rsp_ready = 1'b1;
    step();
    chk("tp4_refill_gnt", 32'(obs_dg), 1);
    chk("tp4_new_pfn", 32'(dm_rsp_pfn), 32'h00400);
    dm_req = 1'b0;
    step();
    // feature check: kseg0 and useg
    if_req = 1'b1; if_vpn = 20'h9FC00;
    step();
    chk("tp5_k0_pfn", 32'(if_rsp_pfn), 32'h1FC00);
    chk("tp5_k0_unc", 32'(if_rsp_uncache), 32'(!CACHE_EN));
    if_vpn = 20'h00400;
    step();
    chk("tp5_useg_pfn", 32'(if_rsp_pfn), 32'h00400);
    if_req = 1'b0;
    step();
    // reset the cycle after a grant
    if_req = 1'b1; if_vpn = 20'hA0005; if_rsp_ready = 1'b0;
    step();
    if_req = 1'b0;
    chk("tp6_pre_valid", 32'(if_rsp_valid), 1);
    #2 reset = 1'b1;
    #1;
    chk("tp6_async_clear", 32'(if_rsp_valid), 0);
    model_reset();
    @(posedge clk); #1 reset = 1'b0;
    if_rsp_ready = 1'b1;
    step(); step();
    chk("tp6_stays_clear", 32'(if_rsp_valid), 0);
    // randomized traffic honouring hold-until-grant
    for (int n = 0; n < 500; n++) begin
      if_rsp_ready = 1'($urandom_range(0, 3) != 0);
      dm_rsp_ready = 1'($urandom_range(0, 2) != 0);
      if (!if_req) begin if_req = 1'($urandom); if_vpn = rand_vpn(); end
      if (!dm_req) begin dm_req = 1'($urandom); dm_vpn = rand_vpn(); end
      step();
      if (obs_ig) begin if_req = 1'($urandom_range(0, 3) != 0); if_vpn = rand_vpn(); end
      if (obs_dg) begin dm_req = 1'($urandom_range(0, 3) != 0); dm_vpn = rand_vpn(); end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
